// File: rtl/spw_pio_pkg.sv
// Shared constants for the SpaceWire status PIO: Avalon register map and
// edge-type encodings.
package spw_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/spw_sync_ff.sv
// Multi-flop synchronizer for a bus of independent asynchronous status bits.
module spw_sync_ff #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  // NOTE: this flop array is reset on purpose, so an edge half-way through
  // the chain cannot survive a reset and be captured afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      // NOTE: non-blocking, so each stage takes its neighbour's old value.
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/cpu_spw_status_in.sv
// Avalon-MM status input port: synchronizes SpaceWire status bits, captures
// edges into a sticky W1C register and raises a masked level interrupt.
module cpu_spw_status_in
  import spw_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] r_prev_q;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_capture;
  logic [31:0]      w_rd_mux;
  logic [31:0]      r_readdata;
  logic             w_wr;
  logic             w_unused_wdata;

  spw_sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_sync_q)
  );

  assign w_wr           = chipselect && !write_n;
  assign w_clear        = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALLING: w_edge = ~w_sync_q & r_prev_q;
      EDGE_ANY:     w_edge = w_sync_q ^ r_prev_q;
      default:      w_edge = w_sync_q & ~r_prev_q;
    endcase
  end

  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = 32'(w_sync_q);
      ADDR_MASK: w_rd_mux = 32'(r_irq_mask);
      ADDR_EDGE: w_rd_mux = 32'(r_edge_capture);
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_q       <= '0;
      r_irq_mask     <= '0;
      r_edge_capture <= '0;
      r_readdata     <= '0;
    end else begin
      r_prev_q   <= w_sync_q;
      r_readdata <= w_rd_mux;
      if (w_wr && address == ADDR_MASK) r_irq_mask <= writedata[WIDTH-1:0];
      // A new edge wins over a simultaneous write-1-to-clear of the same bit.
      r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_cpu_spw_status_in.sv
// Self-checking bench for cpu_spw_status_in: directed register-map scenarios
// followed by randomized bus/pin traffic, against a sample-history model.
module tb_cpu_spw_status_in;
  import spw_pio_pkg::*;

  localparam int WIDTH  = 8;
  localparam int EDGE_T = EDGE_RISING;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '0;
  logic [1:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  cpu_spw_status_in #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_T),
    .SYNC_STAGES (STAGES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: the pin value seen by the CPU is the sample taken
  // STAGES clocks ago; a change between two consecutive visible samples is
  // recorded one clock later. Everything else is the plain register map.
  logic [WIDTH-1:0] m_hist [0:STAGES];
  logic [WIDTH-1:0] m_mask = '0;
  logic [WIDTH-1:0] m_ecap = '0;
  logic [31:0]      m_rd   = '0;

  function automatic logic [WIDTH-1:0] edges_between(input logic [WIDTH-1:0] later,
                                                     input logic [WIDTH-1:0] earlier);
    case (EDGE_T)
      EDGE_FALLING: return ~later & earlier;
      EDGE_ANY:     return later ^ earlier;
      default:      return later & ~earlier;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= STAGES; j++) m_hist[j] <= '0;
      m_mask <= '0;
      m_ecap <= '0;
      m_rd   <= '0;
    end else begin
      case (address)
        2'd0:    m_rd <= 32'(m_hist[STAGES-1]);
        2'd2:    m_rd <= 32'(m_mask);
        2'd3:    m_rd <= 32'(m_ecap);
        default: m_rd <= '0;
      endcase
      m_hist[0] <= in_port;
      for (int j = 1; j <= STAGES; j++) m_hist[j] <= m_hist[j-1];
      m_ecap <= (m_ecap & ~((chipselect && !write_n && address == 2'd3)
                            ? writedata[WIDTH-1:0] : '0))
                | edges_between(m_hist[STAGES-1], m_hist[STAGES]);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[WIDTH-1:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare both outputs against the model.
  task automatic tick();
    @(negedge clk);
    check("model_readdata", readdata, m_rd);
    check("model_irq", 32'(irq), 32'(|(m_ecap & m_mask)));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    check(tag, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset with the inputs quiet.
    ticks(3);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    bus_read("post_reset_data", 2'd0, 32'd0);
    bus_read("post_reset_mask", 2'd2, 32'd0);
    bus_read("post_reset_edge", 2'd3, 32'd0);

    // Pin value read-back through the synchronizer.
    in_port = 8'hA5;
    ticks(3);
    bus_read("data_a5", 2'd0, 32'h0000_00A5);
    in_port = 8'h00;
    ticks(4);
    bus_write(2'd3, 32'hFF);
    bus_read("edge_cleared", 2'd3, 32'd0);

    // Rising capture raises irq; clearing drops it next cycle.
    bus_write(2'd2, 32'h01);
    in_port = 8'h01;
    ticks(3);
    check("irq_rise_bit0", 32'(irq), 32'd1);
    bus_read("edge_bit0", 2'd3, 32'h01);
    bus_write(2'd3, 32'h01);
    check("irq_after_clear", 32'(irq), 32'd0);

    // Masked edge is captured but does not interrupt until unmasked.
    bus_write(2'd2, 32'h00);
    in_port = 8'h09;
    ticks(3);
    check("irq_masked", 32'(irq), 32'd0);
    bus_read("edge_bit3", 2'd3, 32'h08);
    bus_write(2'd2, 32'h08);
    check("irq_unmasked", 32'(irq), 32'd1);
    bus_write(2'd3, 32'hFF);
    check("irq_cleared", 32'(irq), 32'd0);

    // A new bit-2 edge lands in the same cycle as its clear: set wins.
    in_port = 8'h0D;
    ticks(4);
    bus_read("edge_bit2_set", 2'd3, 32'h04);
    in_port = 8'h09;
    ticks(4);
    bus_read("edge_bit2_sticky", 2'd3, 32'h04);
    in_port = 8'h0D;
    ticks(2);
    bus_write(2'd3, 32'h04);
    bus_read("set_beats_clear", 2'd3, 32'h04);

    // Partial clear; writes to data/reserved change nothing.
    bus_write(2'd3, 32'hFF);
    in_port = 8'h00;
    ticks(4);
    in_port = 8'h0F;
    ticks(4);
    bus_read("edge_0f", 2'd3, 32'h0F);
    bus_write(2'd3, 32'h05);
    bus_read("partial_clear", 2'd3, 32'h0A);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hFF);
    bus_read("ro_write_edge", 2'd3, 32'h0A);
    bus_read("ro_write_mask", 2'd2, 32'h08);
    bus_read("reserved_zero", 2'd1, 32'h0);
    bus_read("ro_write_data", 2'd0, 32'h0F);

    // Reset mid-run while a bit-4 edge is still inside the synchronizer.
    in_port = 8'h10;
    tick();
    reset_n = 1'b0;
    in_port = 8'h00;
    ticks(2);
    check("midrun_reset_irq", 32'(irq), 32'd0);
    check("midrun_reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    ticks(5);
    bus_read("abandon_edge", 2'd3, 32'd0);
    bus_read("abandon_mask", 2'd2, 32'd0);
    bus_read("abandon_data", 2'd0, 32'd0);

    // A pin already high at reset release looks like a rise from the cleared
    // synchronizer, so it is captured as a genuine edge.
    reset_n = 1'b0;
    in_port = 8'h01;
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    bus_read("high_at_release", 2'd3, 32'h01);
    bus_write(2'd3, 32'hFF);

    // Randomized pin activity and bus traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = WIDTH'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
